// File: rtl/wwfa_scheduler.sv
// Wrapped wave-front arbiter for a 4x4 crossbar: IDLE/ARB/XFER FSM that arbitrates
// requests diagonal by diagonal, locks connections until end-of-packet, rotates priority.
module wwfa_scheduler #(
    parameter logic [3:0] PRIO_INIT = 4'b0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    input  logic [3:0]  eop,
    output logic [15:0] grant,
    output logic [7:0]  cfg_sel,
    output logic [3:0]  cfg_vld,
    output logic [3:0]  prio_diag,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

    state_t      state_q;
    logic [15:0] grant_q, grant_d;
    logic [7:0]  sel_q, sel_d;
    logic [3:0]  vld_q, vld_d;
    logic [3:0]  prio_q;

    logic [1:0]  p_idx;
    logic [3:0]  row_busy, col_busy;
    logic [3:0]  in_used, out_used;
    logic [15:0] new_grant, released;
    logic [3:0]  eff_eop;
    logic [1:0]  d_idx, ii, jj;

    // Occupancy of inputs (rows) and outputs (columns) by locked connections.
    always_comb begin
        row_busy = '0;
        col_busy = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                row_busy[i] = row_busy[i] | grant_q[4*i+j];
                col_busy[j] = col_busy[j] | grant_q[4*i+j];
            end
        end
    end

    // Wave-front: diagonals p, p+1, p+2, p+3; cells within one diagonal never
    // share a row or column, so only earlier diagonals and locks can block them.
    // NOTE: blocking assignments here are deliberate -- in_used/out_used must see
    // grants made on earlier diagonals within the same evaluation.
    always_comb begin
        p_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (prio_q[i]) p_idx = 2'(i);
        end
        new_grant = '0;
        in_used   = row_busy;
        out_used  = col_busy;
        d_idx     = 2'd0;
        ii        = 2'd0;
        jj        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            d_idx = p_idx + 2'(k);
            for (int i = 0; i < 4; i++) begin
                ii = 2'(i);
                jj = ii + d_idx;
                if (req[{ii, jj}] && !in_used[ii] && !out_used[jj]) begin
                    new_grant[{ii, jj}] = 1'b1;
                    in_used[ii]         = 1'b1;
                    out_used[jj]        = 1'b1;
                end
            end
        end
    end

    // End-of-packet only counts on inputs that actually hold a connection.
    always_comb begin
        eff_eop  = eop & row_busy;
        released = grant_q;
        for (int i = 0; i < 4; i++) begin
            if (eff_eop[i]) released[4*i +: 4] = 4'b0000;
        end
    end

    always_comb begin
        grant_d = grant_q;
        case (state_q)
            ARB:     grant_d = grant_q | new_grant;
            XFER:    if (|eff_eop) grant_d = released;
            default: grant_d = grant_q;
        endcase
    end

    // Crossbar selects follow the next grant matrix; unused outputs select input 0.
    always_comb begin
        sel_d = '0;
        vld_d = '0;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                if (grant_d[4*i+j]) begin
                    vld_d[j]       = 1'b1;
                    sel_d[2*j +: 2] = 2'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            vld_q   <= '0;
            prio_q  <= PRIO_INIT;
        end else begin
            grant_q <= grant_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            case (state_q)
                IDLE: if (|req) state_q <= ARB;
                ARB: begin
                    if (|new_grant) prio_q <= {prio_q[0], prio_q[3:1]};
                    state_q <= (|grant_d) ? XFER : IDLE;
                end
                XFER: if (|eff_eop) state_q <= ARB;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign cfg_sel   = sel_q;
    assign cfg_vld   = vld_q;
    assign prio_diag = prio_q;
    assign busy      = (state_q != IDLE);

endmodule
